// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// operation latencies and FSM states.
package mdu_pkg;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [3:0] MULT_CYCLES = 4'd5;
   localparam logic [3:0] DIV_CYCLES  = 4'd10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;
endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit. The result is computed in the accepting cycle
// and held in pending registers; a down-counter models latency before commit.
module mult_div_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] hilo_rd
);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] hi, lo;
   logic [31:0] pend_hi, pend_lo;
   logic        pend_en;

   logic [63:0] prod_s, prod_u;
   logic [31:0] b_nz, quot_s, rem_s, quot_u, rem_u;
   logic [31:0] res_hi, res_lo;
   logic        res_en;
   logic        is_md;

   // Divisor forced non-zero so the operators never produce X; the b=0
   // case is suppressed at commit via res_en instead.
   always_comb begin
      prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      prod_u = {32'b0, a} * {32'b0, b};
      b_nz   = (b == 32'd0) ? 32'd1 : b;
      quot_s = $signed(a) / $signed(b_nz);
      rem_s  = $signed(a) % $signed(b_nz);
      quot_u = a / b_nz;
      rem_u  = a % b_nz;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         quot_s = 32'h8000_0000;
         rem_s  = 32'd0;
      end
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_en = 1'b1;
      is_md  = 1'b1;
      case (op)
         OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
         OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
         OP_DIV:   begin res_hi = rem_s; res_lo = quot_s; res_en = (b != 32'd0); end
         OP_DIVU:  begin res_hi = rem_u; res_lo = quot_u; res_en = (b != 32'd0); end
         default:  is_md = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= 4'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_en <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (is_md) begin
                     pend_hi <= res_hi;
                     pend_lo <= res_lo;
                     pend_en <= res_en;
                     cnt     <= (op == OP_MULT || op == OP_MULTU) ? MULT_CYCLES : DIV_CYCLES;
                     state   <= ST_BUSY;
                  end else if (op == OP_MTHI) begin
                     hi <= a;
                  end else if (op == OP_MTLO) begin
                     lo <= a;
                  end
               end
            end
            ST_BUSY: begin
               if (cnt <= 4'd1) begin
                  cnt   <= 4'd0;
                  state <= ST_IDLE;
                  if (pend_en) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (state == ST_BUSY);
   assign hilo_rd = rd_sel ? hi : lo;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is synchronous and active-high.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Port: start  in  1  E-stage request qualifier, sampled every rising edge.
REQ-005 Port: op  in  3  operation code:
- 000 mult
- 001 multu
- 010 div
- 011 divu
- 100 mthi
- 101 mtlo
- 110 and 111 no-op
REQ-006 Port: a  in  32  operand A (rs value, already forwarded).
REQ-007 Port: b  in  32  operand B (rt value, already forwarded).
REQ-008 Port: rd_sel  in  1  read select: 0 = LO, 1 = HI.
REQ-009 Port: busy  out  1  high while a mult/div is in flight; feeds the hazard unit.
REQ-010 Port: hilo_rd  out  32  combinational read of the committed HI or LO per rd_sel; feeds the E/M register hilo input.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and BUSY, with a 4-bit down-counter.
REQ-012 In IDLE, start=1 with op 000-011 SHALL, at that edge:
- capture the full result into pending registers;
- load the counter with 5 for mult/multu or 10 for div/divu;
- enter BUSY.
REQ-013 busy SHALL be high for exactly N consecutive cycles starting the cycle after the accepting edge, where N is 5 (mult) or 10 (div).
REQ-014 On the edge where the counter reaches 0, the FSM SHALL return to IDLE, deassert busy, and copy the pending HI/LO into committed HI/LO.
REQ-015 New HI/LO values SHALL be visible on hilo_rd from the first cycle busy is low, and never earlier.
REQ-016 mult SHALL form a signed 64-bit product and multu an unsigned one: HI = bits 63:32, LO = bits 31:0.
REQ-017 div/divu SHALL produce LO = quotient and HI = remainder; signed division truncates toward zero and the remainder takes the sign of the dividend.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
REQ-019 Division with b=0 SHALL still hold busy for 10 cycles and SHALL leave HI/LO unchanged at commit.
REQ-020 In IDLE, start=1 with op 100 SHALL write a into HI, and op 101 SHALL write a into LO, at that edge with no busy cycle.
REQ-021 While in BUSY, start=1 with any op SHALL be ignored, including mthi/mtlo; the hazard unit guarantees stalls.
REQ-022 start=0, or op 110/111, SHALL cause no state change.
REQ-023 hilo_rd SHALL reflect committed registers only; pending values SHALL never be exposed.
REQ-024 The counter SHALL never wrap: it SHALL hold at 0 in IDLE.

Reset
REQ-025 reset=1 at a rising edge SHALL force the FSM to IDLE, the counter to 0, busy=0, HI=0, LO=0 and pending registers to 0.
REQ-026 Reset SHALL take priority over start and over a commit occurring on the same edge.
REQ-027 Reset asserted mid-operation SHALL abort the operation: no commit, and hilo_rd reads 0 the following cycle.

Structure
REQ-028 A shared package mdu_pkg SHALL hold:
- the op encodings;
- MULT_CYCLES=5 and DIV_CYCLES=10;
- the state enumeration.
REQ-029 The block SHALL be a single module with no sub-modules; arithmetic SHALL use native operators computed in the accepting cycle.
REQ-030 The block SHALL be instantiated in the E stage, alongside the ALU, with hilo_rd driving the E/M register hilo input.

Verification
REQ-031 mult, a=7, b=0xFFFFFFFD -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-032 multu, a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles; a multu start issued at busy cycle 2 is ignored.
REQ-033 div, a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; hilo_rd shows old values throughout busy.
REQ-034 Preload HI=0x11, LO=0x22 via mthi/mtlo, then divu with b=0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
REQ-035 mult started, reset asserted at busy cycle 3 -> next cycle busy=0, HI=LO=0, and no later commit occurs.
REQ-036 mtlo a=0xDEADBEEF in IDLE -> rd_sel=0 reads 0xDEADBEEF the next cycle, busy never asserts.
